// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state type and constants for the memory port arbiter
//
// Contents:
//   arb_state_t : arbiter FSM states (IDLE, IF_WAIT, D0_WAIT, D1_WAIT)
//   BE_W        : byte-enable width of the 32-bit memory port
//   BE_WORD     : full-word byte enable
//   BE_BYTE0    : byte enable for lane 0, shifted by the byte offset
//   DW_STRIDE   : address step between the two beats of a double-word access
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_WAIT = 2'd1,
        D0_WAIT = 2'd2,
        D1_WAIT = 2'd3
    } arb_state_t;

    localparam int            BE_W      = 4;
    localparam logic [BE_W-1:0] BE_WORD  = 4'hF;
    localparam logic [BE_W-1:0] BE_BYTE0 = 4'h1;
    localparam int            DW_STRIDE = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - single 32-bit memory port bundle
//
// Signals:
//   mem_req   : beat request, held until mem_ack
//   mem_we    : beat is a write
//   mem_be    : byte enables
//   mem_addr  : word-aligned byte address
//   mem_wdata : write data
//   mem_rdata : read data, valid with mem_ack
//   mem_ack   : beat complete
// Modports:
//   master : arbiter side (drives the request fields)
//   slave  : memory side (drives rdata/ack)
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    import mem_arb_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [BE_W-1:0]   mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_be,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_be,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );

endinterface

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane steering for the 32-bit memory port
//
// Purely combinational.
// Ports:
//   byte_sel  : in  address bits [1:0] of the access
//   is_byte   : in  access is a single byte
//   wdata_in  : in  store word from the requester
//   rdata_in  : in  word returned by memory
//   be        : out byte enables (one lane for bytes, all four otherwise)
//   wdata_out : out store word, byte replicated on all lanes for byte stores
//   rdata_out : out load word, selected lane zero-extended for byte loads
module mem_lane_align
    import mem_arb_pkg::*;
(
    input  logic [1:0]      byte_sel,
    input  logic            is_byte,
    input  logic [31:0]     wdata_in,
    input  logic [31:0]     rdata_in,
    output logic [BE_W-1:0] be,
    output logic [31:0]     wdata_out,
    output logic [31:0]     rdata_out
);

    always_comb begin
        be        = BE_WORD;
        wdata_out = wdata_in;
        rdata_out = rdata_in;
        if (is_byte) begin
            be        = BE_BYTE0 << byte_sel;
            // Replicating the byte lets memory pick whichever lane be selects.
            wdata_out = {4{wdata_in[7:0]}};
            case (byte_sel)
                2'd0:    rdata_out = {24'h0, rdata_in[7:0]};
                2'd1:    rdata_out = {24'h0, rdata_in[15:8]};
                2'd2:    rdata_out = {24'h0, rdata_in[23:16]};
                default: rdata_out = {24'h0, rdata_in[31:24]};
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one 32-bit memory port between fetch and MEM-stage data
//
// Optional feature macro: ALIGN_CHECK_EN (adds ex_misalign and faults misaligned
// word/double-word accesses; without it the low address bits are forced to zero).
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   if_req/if_addr, if_rdata/if_valid : fetch request and one-cycle result pulse
//   ex_req/ex_we/ex_byte/ex_dw/ex_addr/ex_wdata : data request (held until ex_done)
//   ex_rdata/ex_done : 64-bit load result and one-cycle completion pulse
//   ex_misalign  : fault pulse alongside ex_done (ALIGN_CHECK_EN only)
//   stall_if, stall_mem : per-requester stalls for the pipeline
//   mem          : memory port bundle (master side), all fields registered
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_valid,
    input  logic                ex_req,
    input  logic                ex_we,
    input  logic                ex_byte,
    input  logic                ex_dw,
    input  logic [ADDR_W-1:0]   ex_addr,
    input  logic [2*DATA_W-1:0] ex_wdata,
    output logic [2*DATA_W-1:0] ex_rdata,
    output logic                ex_done,
`ifdef ALIGN_CHECK_EN
    output logic                ex_misalign,
`endif
    output logic                stall_if,
    output logic                stall_mem,
    mem_port_arbiter_if.master  mem
);

    arb_state_t state, state_n;

    logic              req_q, req_n;
    logic              we_q, we_n;
    logic [BE_W-1:0]   be_q, be_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [DATA_W-1:0] wdata_q, wdata_n;

    logic [DATA_W-1:0]   if_rdata_n;
    logic                if_valid_n;
    logic                ex_done_n;
    logic [2*DATA_W-1:0] ex_rdata_n;
    logic                pref_if, pref_if_n;

    // Request fields captured at grant; the requester may change its inputs afterwards.
    logic              lat_byte, lat_byte_n;
    logic              lat_dw, lat_dw_n;
    logic [1:0]        lat_sel, lat_sel_n;
    logic [DATA_W-1:0] lat_whi, lat_whi_n;

    logic              grant_if, grant_ex;
    logic [ADDR_W-1:0] data_addr;
    logic              lane_byte;
    logic [1:0]        lane_sel;
    logic [BE_W-1:0]   lane_be;
    logic [31:0]       lane_wdata;
    logic [31:0]       lane_rdata;
    logic              unused_if_lsb;

`ifdef ALIGN_CHECK_EN
    logic misaligned;
    logic misalign_n;

    assign misaligned = ex_dw ? (ex_addr[2:0] != 3'b000)
                              : (!ex_byte && (ex_addr[1:0] != 2'b00));
`endif

    assign unused_if_lsb = ^if_addr[1:0];

    // Fetch wins only while it is owed a turn; otherwise data goes first.
    assign grant_if = (state == IDLE) && if_req && (!ex_req || pref_if);
    assign grant_ex = (state == IDLE) && ex_req && !grant_if;

    // Word address for the first beat; a DW always starts on an 8-byte boundary.
    assign data_addr = ex_dw ? {ex_addr[ADDR_W-1:3], 3'b000}
                             : {ex_addr[ADDR_W-1:2], 2'b00};

    // In IDLE the lane logic shapes the outgoing store from live inputs; while
    // waiting it extracts the load from the latched offset.
    assign lane_sel  = (state == IDLE) ? ex_addr[1:0] : lat_sel;
    assign lane_byte = (state == IDLE) ? (ex_byte & ~ex_dw) : lat_byte;

    mem_lane_align u_lane (
        .byte_sel  (lane_sel),
        .is_byte   (lane_byte),
        .wdata_in  (ex_wdata[DATA_W-1:0]),
        .rdata_in  (mem.mem_rdata),
        .be        (lane_be),
        .wdata_out (lane_wdata),
        .rdata_out (lane_rdata)
    );

    always_comb begin
        state_n    = state;
        req_n      = req_q;
        we_n       = we_q;
        be_n       = be_q;
        addr_n     = addr_q;
        wdata_n    = wdata_q;
        if_rdata_n = if_rdata;
        if_valid_n = 1'b0;
        ex_done_n  = 1'b0;
        ex_rdata_n = ex_rdata;
        pref_if_n  = pref_if;
        lat_byte_n = lat_byte;
        lat_dw_n   = lat_dw;
        lat_sel_n  = lat_sel;
        lat_whi_n  = lat_whi;
`ifdef ALIGN_CHECK_EN
        misalign_n = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (grant_if) begin
                    state_n   = IF_WAIT;
                    req_n     = 1'b1;
                    we_n      = 1'b0;
                    be_n      = BE_WORD;
                    addr_n    = {if_addr[ADDR_W-1:2], 2'b00};
                    pref_if_n = 1'b0;
                end else if (grant_ex) begin
                    lat_byte_n = ex_byte & ~ex_dw;
                    lat_dw_n   = ex_dw;
                    lat_sel_n  = ex_addr[1:0];
                    lat_whi_n  = ex_wdata[2*DATA_W-1:DATA_W];
`ifdef ALIGN_CHECK_EN
                    if (misaligned) begin
                        // Fault without touching memory; stay in IDLE.
                        ex_done_n  = 1'b1;
                        misalign_n = 1'b1;
                        if (if_req) pref_if_n = 1'b1;
                    end else
`endif
                    begin
                        state_n = D0_WAIT;
                        req_n   = 1'b1;
                        we_n    = ex_we;
                        be_n    = lane_be;
                        addr_n  = data_addr;
                        wdata_n = lane_wdata;
                    end
                end
            end
            IF_WAIT: begin
                if (mem.mem_ack) begin
                    req_n      = 1'b0;
                    if_rdata_n = mem.mem_rdata;
                    if_valid_n = 1'b1;
                    state_n    = IDLE;
                end
            end
            D0_WAIT: begin
                if (req_q && mem.mem_ack) begin
                    req_n = 1'b0;
                    if (!we_q) ex_rdata_n[DATA_W-1:0] = lane_rdata;
                    if (lat_dw) begin
                        // Second beat goes out after one idle cycle on the port.
                        state_n = D1_WAIT;
                        addr_n  = addr_q + ADDR_W'(DW_STRIDE);
                        wdata_n = lat_whi;
                    end else begin
                        ex_done_n = 1'b1;
                        state_n   = IDLE;
                        if (if_req) pref_if_n = 1'b1;
                    end
                end
            end
            D1_WAIT: begin
                if (!req_q) begin
                    req_n = 1'b1;
                end else if (mem.mem_ack) begin
                    req_n = 1'b0;
                    if (!we_q) ex_rdata_n[2*DATA_W-1:DATA_W] = mem.mem_rdata;
                    ex_done_n = 1'b1;
                    state_n   = IDLE;
                    if (if_req) pref_if_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            be_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            if_rdata <= '0;
            if_valid <= 1'b0;
            ex_done  <= 1'b0;
            ex_rdata <= '0;
            pref_if  <= 1'b0;
            lat_byte <= 1'b0;
            lat_dw   <= 1'b0;
            lat_sel  <= '0;
            lat_whi  <= '0;
`ifdef ALIGN_CHECK_EN
            ex_misalign <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            req_q    <= req_n;
            we_q     <= we_n;
            be_q     <= be_n;
            addr_q   <= addr_n;
            wdata_q  <= wdata_n;
            if_rdata <= if_rdata_n;
            if_valid <= if_valid_n;
            ex_done  <= ex_done_n;
            ex_rdata <= ex_rdata_n;
            pref_if  <= pref_if_n;
            lat_byte <= lat_byte_n;
            lat_dw   <= lat_dw_n;
            lat_sel  <= lat_sel_n;
            lat_whi  <= lat_whi_n;
`ifdef ALIGN_CHECK_EN
            ex_misalign <= misalign_n;
`endif
        end
    end

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_be    = be_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

    assign stall_if  = if_req & ~if_valid;
    assign stall_mem = ex_req & ~ex_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        ex_req, ex_we, ex_byte, ex_dw;
    logic [31:0] ex_addr;
    logic [63:0] ex_wdata;
    logic [63:0] ex_rdata;
    logic        ex_done;
`ifdef ALIGN_CHECK_EN
    logic        ex_misalign;
`endif
    logic        stall_if, stall_mem;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .ex_req    (ex_req),
        .ex_we     (ex_we),
        .ex_byte   (ex_byte),
        .ex_dw     (ex_dw),
        .ex_addr   (ex_addr),
        .ex_wdata  (ex_wdata),
        .ex_rdata  (ex_rdata),
        .ex_done   (ex_done),
`ifdef ALIGN_CHECK_EN
        .ex_misalign (ex_misalign),
`endif
        .stall_if  (stall_if),
        .stall_mem (stall_mem),
        .mem       (mem)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } beat_t;

    beat_t       beat_exp[$];
    logic [31:0] exp_if[$];
    logic [63:0] exp_ex[$];
    logic [31:0] mem_arr [0:255];
    logic [63:0] ex_model = '0;
    int          lat = 2;
    int          cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_beat(input logic we, input logic [3:0] be, input logic [31:0] addr,
                             input logic [31:0] wdata);
        beat_t b;
        b.we = we; b.be = be; b.addr = addr; b.wdata = wdata;
        beat_exp.push_back(b);
    endtask

    // Memory: acks after lat cycles of mem_req; checks each new beat against the scoreboard.
    always @(negedge clk) begin
        beat_t b;
        if (mem.mem_ack) begin
            mem.mem_ack = 1'b0;
            cnt = 0;
        end else if (mem.mem_req) begin
            cnt++;
            if (cnt == 1) begin
                chk("beat_expected", 64'(beat_exp.size() != 0), 64'd1);
                if (beat_exp.size() != 0) begin
                    b = beat_exp.pop_front();
                    chk("beat_addr", 64'(mem.mem_addr), 64'(b.addr));
                    chk("beat_be", 64'(mem.mem_be), 64'(b.be));
                    chk("beat_we", 64'(mem.mem_we), 64'(b.we));
                    if (b.we) chk("beat_wdata", 64'(mem.mem_wdata), 64'(b.wdata));
                end
            end
            if (cnt >= lat) begin
                mem.mem_rdata = mem_arr[mem.mem_addr[9:2]];
                if (mem.mem_we)
                    for (int i = 0; i < 4; i++)
                        if (mem.mem_be[i]) mem_arr[mem.mem_addr[9:2]][i*8 +: 8] = mem.mem_wdata[i*8 +: 8];
                mem.mem_ack = 1'b1;
            end
        end
    end

    task automatic ex_start(input logic we, input logic byt, input logic dw,
                            input logic [31:0] addr, input logic [63:0] wdata);
        ex_we = we; ex_byte = byt; ex_dw = dw; ex_addr = addr; ex_wdata = wdata;
        ex_req = 1'b1;
    endtask

    task automatic wait_ex(input int max);
        bit seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge clk);
            if (ex_done) begin
                seen = 1'b1;
                chk("stall_mem_at_done", 64'(stall_mem), 64'd0);
                chk("ex_sb_nonempty", 64'(exp_ex.size() != 0), 64'd1);
                if (exp_ex.size() != 0) chk("ex_rdata", ex_rdata, exp_ex.pop_front());
                ex_req = 1'b0;
            end else begin
                chk("stall_mem_wait", 64'(stall_mem), 64'd1);
            end
        end
        chk("ex_done_seen", 64'(seen), 64'd1);
    endtask

    task automatic wait_if(input int max);
        bit seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge clk);
            if (if_valid) begin
                seen = 1'b1;
                chk("stall_if_at_valid", 64'(stall_if), 64'd0);
                chk("if_sb_nonempty", 64'(exp_if.size() != 0), 64'd1);
                if (exp_if.size() != 0) chk("if_rdata", 64'(if_rdata), 64'(exp_if.pop_front()));
                if_req = 1'b0;
            end else begin
                chk("stall_if_wait", 64'(stall_if), 64'd1);
            end
        end
        chk("if_valid_seen", 64'(seen), 64'd1);
    endtask

    initial begin
        bit hit;
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        ex_req = 1'b0; ex_we = 1'b0; ex_byte = 1'b0; ex_dw = 1'b0; ex_addr = '0; ex_wdata = '0;
        mem.mem_ack = 1'b0;
        mem.mem_rdata = '0;
        for (int i = 0; i < 256; i++) mem_arr[i] = 32'h0;
        mem_arr[32'h100 >> 2] = 32'h8C220004;
        mem_arr[32'h040 >> 2] = 32'hCAFEF00D;
        mem_arr[32'h300 >> 2] = 32'h00001234;
        mem_arr[32'h200 >> 2] = 32'h11223344;
        mem_arr[32'h080 >> 2] = 32'hDEADBEEF;
        mem_arr[32'h084 >> 2] = 32'h3FF00000;

        repeat (3) @(negedge clk);
        chk("rst_mem_req", 64'(mem.mem_req), 64'd0);
        chk("rst_mem_be", 64'(mem.mem_be), 64'd0);
        chk("rst_mem_addr", 64'(mem.mem_addr), 64'd0);
        chk("rst_if_valid", 64'(if_valid), 64'd0);
        chk("rst_ex_done", 64'(ex_done), 64'd0);
        chk("rst_ex_rdata", ex_rdata, 64'd0);
        chk("rst_if_rdata", 64'(if_rdata), 64'd0);
        chk("rst_state", 64'(dut.state), 64'(IDLE));
        rst = 1'b0;

        // Fetch only, latency 2
        lat = 2;
        push_beat(1'b0, 4'hF, 32'h100, 32'h0);
        exp_if.push_back(32'h8C220004);
        if_addr = 32'h100; if_req = 1'b1;
        wait_if(20);

        // Simultaneous requests: data first, then the owed fetch beats a new data request
        lat = 1;
        push_beat(1'b0, 4'hF, 32'h040, 32'h0);
        push_beat(1'b0, 4'hF, 32'h300, 32'h0);
        push_beat(1'b1, 4'hF, 32'h044, 32'h55667788);
        ex_model = {ex_model[63:32], 32'hCAFEF00D};
        exp_ex.push_back(ex_model);
        exp_if.push_back(32'h00001234);
        if_addr = 32'h300; if_req = 1'b1;
        ex_start(1'b0, 1'b0, 1'b0, 32'h40, 64'h0);
        wait_ex(20);
        chk("stall_if_loser", 64'(stall_if), 64'd1);
        ex_start(1'b1, 1'b0, 1'b0, 32'h44, 64'hFFFFFFFF_55667788);
        exp_ex.push_back(ex_model);
        wait_if(20);
        wait_ex(20);

        // Byte load then byte store in the same word
        lat = 2;
        push_beat(1'b0, 4'b0010, 32'h200, 32'h0);
        ex_model = {ex_model[63:32], 32'h00000033};
        exp_ex.push_back(ex_model);
        ex_start(1'b0, 1'b1, 1'b0, 32'h201, 64'h0);
        wait_ex(20);
        push_beat(1'b1, 4'b1000, 32'h200, 32'hA5A5A5A5);
        exp_ex.push_back(ex_model);
        ex_start(1'b1, 1'b1, 1'b0, 32'h203, 64'h12345678_9ABCDEA5);
        wait_ex(20);

        // DW load: two beats, one done pulse
        push_beat(1'b0, 4'hF, 32'h080, 32'h0);
        push_beat(1'b0, 4'hF, 32'h084, 32'h0);
        ex_model = 64'h3FF00000_DEADBEEF;
        exp_ex.push_back(ex_model);
        ex_start(1'b0, 1'b0, 1'b1, 32'h80, 64'h0);
        wait_ex(40);
        @(negedge clk);
        chk("ex_done_single", 64'(ex_done), 64'd0);

        // DW store with Byte also set: Byte ignored
        push_beat(1'b1, 4'hF, 32'h088, 32'h22222222);
        push_beat(1'b1, 4'hF, 32'h08C, 32'h11111111);
        exp_ex.push_back(ex_model);
        ex_start(1'b1, 1'b1, 1'b1, 32'h88, 64'h11111111_22222222);
        wait_ex(40);

        // DW at 0x84
`ifdef ALIGN_CHECK_EN
        hit = 1'b0;
        ex_start(1'b0, 1'b0, 1'b1, 32'h84, 64'h0);
        for (int i = 0; i < 10 && !hit; i++) begin
            @(negedge clk);
            if (ex_done) begin
                hit = 1'b1;
                chk("misalign_pulse", 64'(ex_misalign), 64'd1);
                chk("misalign_rdata", ex_rdata, ex_model);
                ex_req = 1'b0;
            end
        end
        chk("misalign_done_seen", 64'(hit), 64'd1);
        @(negedge clk);
        chk("misalign_single", 64'(ex_misalign), 64'd0);
`else
        push_beat(1'b0, 4'hF, 32'h080, 32'h0);
        push_beat(1'b0, 4'hF, 32'h084, 32'h0);
        exp_ex.push_back(ex_model);
        ex_start(1'b0, 1'b0, 1'b1, 32'h84, 64'h0);
        wait_ex(40);
`endif

        // Reset in D1_WAIT as the second ack arrives
        lat = 3;
        push_beat(1'b0, 4'hF, 32'h080, 32'h0);
        push_beat(1'b0, 4'hF, 32'h084, 32'h0);
        ex_start(1'b0, 1'b0, 1'b1, 32'h80, 64'h0);
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            #1;
            if (mem.mem_ack && dut.state == D1_WAIT) begin
                hit = 1'b1;
                rst = 1'b1;
            end
        end
        chk("reset_in_d1", 64'(hit), 64'd1);
        @(posedge clk);
        #1;
        chk("reset_mem_req", 64'(mem.mem_req), 64'd0);
        chk("reset_state", 64'(dut.state), 64'(IDLE));
        rst = 1'b0;
        ex_req = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("reset_no_done", 64'(ex_done), 64'd0);
        end
        chk("reset_ex_rdata", ex_rdata, 64'd0);
        chk("reset_idle_req", 64'(mem.mem_req), 64'd0);

        chk("beats_left", 64'(beat_exp.size()), 64'd0);
        chk("ex_left", 64'(exp_ex.size()), 64'd0);
        chk("if_left", 64'(exp_if.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
